// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: the request FSM states
// and the per-instruction byte step.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   function automatic int unsigned instr_bytes(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/ack handshake plus the decode valid/ready port.
// The master side is the fetch unit; the slave side is memory plus decode.
interface fetch_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) ();

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_ack, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_ack, imem_rdata, instr_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, instruction} pairs; count is kept separately from
// the wrapping pointers so full and empty are distinguishable.
module fetch_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign valid = (count_q != '0);
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: request FSM, pc, slot reservation and prefetch queue.
// Optional FETCH_BYPASS_EN forwards acked data straight to decode when the queue is empty.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DATA_W   = 16,
   parameter int          ADDR_W   = 16,
   parameter int          DEPTH    = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fetch_if.master                bus,
   input  logic                   redirect,
   input  logic [ADDR_W-1:0]      redirect_pc,
   input  logic                   halt,
   output logic [ADDR_W-1:0]      pc,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int                OCC_W      = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(instr_bytes(DATA_W));
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

   fetch_state_e              state_q, state_d;
   logic                      imem_req_q, imem_req_d;
   logic [ADDR_W-1:0]         imem_addr_q, imem_addr_d;
   logic [ADDR_W-1:0]         pc_q, pc_d;

   logic                      ack, q_push, q_pop, q_valid, bypass, issue_ok;
   logic [OCC_W-1:0]          q_count, occ_after;
   logic [ADDR_W+DATA_W-1:0]  q_rdata;

   assign ack   = bus.imem_ack & imem_req_q;
   assign q_pop = q_valid & bus.instr_ready & ~redirect;

`ifdef FETCH_BYPASS_EN
   assign bypass = ack & (state_q == BUSY) & ~redirect & ~q_valid & bus.instr_ready;
`else
   assign bypass = 1'b0;
`endif

   // A new request may only go out if its word is guaranteed a free slot.
   assign q_push    = ack & (state_q == BUSY) & ~redirect & ~bypass;
   assign occ_after = q_count + OCC_W'(q_push) - OCC_W'(q_pop);
   assign issue_ok  = (occ_after < OCC_W'(DEPTH)) & ~halt & ~redirect;

   always_comb begin
      state_d     = state_q;
      imem_addr_d = imem_addr_q;
      pc_d        = pc_q;
      case (state_q)
         IDLE: begin
            if (issue_ok) begin
               state_d     = BUSY;
               imem_addr_d = pc_q;
               pc_d        = pc_q + STEP;
            end
         end
         BUSY: begin
            if (ack) begin
               if (issue_ok) begin
                  imem_addr_d = pc_q;
                  pc_d        = pc_q + STEP;
               end else begin
                  state_d = IDLE;
               end
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (redirect) begin
         pc_d = redirect_pc;
      end
      imem_req_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         imem_req_q  <= 1'b0;
         imem_addr_q <= RESET_ADDR;
         pc_q        <= RESET_ADDR;
      end else begin
         state_q     <= state_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         pc_q        <= pc_d;
      end
   end

   fetch_queue #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect),
      .push  (q_push),
      .pop   (q_pop),
      .wdata ({imem_addr_q, bus.imem_rdata}),
      .rdata (q_rdata),
      .valid (q_valid),
      .count (q_count)
   );

   assign bus.imem_req    = imem_req_q;
   assign bus.imem_addr   = imem_addr_q;
   assign bus.instr_valid = q_valid | bypass;
   assign bus.instr       = bypass ? bus.imem_rdata : q_rdata[DATA_W-1:0];
   assign bus.instr_pc    = bypass ? imem_addr_q : q_rdata[ADDR_W+DATA_W-1:DATA_W];
   assign pc              = pc_q;
   assign occupancy       = q_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a variable-latency memory model feeds the DUT and a
// scoreboard monitor checks every word handed to decode against the expected queue.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic [15:0] pc;
   logic [2:0]  occupancy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int memLat   = 1;
   int memCnt   = 0;

   logic [15:0] expPc[$];
   logic [15:0] expData[$];

`ifdef FETCH_BYPASS_EN
   localparam logic BYPASS_VALID = 1'b1;
`else
   localparam logic BYPASS_VALID = 1'b0;
`endif

   fetch_if #(.ADDR_W(16), .DATA_W(16)) bus_if ();

   fetch_unit #(
      .DATA_W   (16),
      .ADDR_W   (16),
      .DEPTH    (4),
      .RESET_PC (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_if.master),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .pc          (pc),
      .occupancy   (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: each word is a scramble of its own address.
   function automatic logic [15:0] memWord(input logic [15:0] addr);
      return {addr[7:0], addr[15:8]} ^ 16'hC3A5;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic waitCycle(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic applyStimulus(input int atCycle, input logic haltV, input logic readyV,
                                input logic redirV, input logic [15:0] redirPc);
      waitCycle(atCycle);
      halt               = haltV;
      bus_if.instr_ready = readyV;
      redirect           = redirV;
      redirect_pc        = redirPc;
   endtask

   task automatic expectPc(input logic [15:0] p);
      expPc.push_back(p);
      expData.push_back(memWord(p));
   endtask

   // Memory model: acks each request after memLat cycles of imem_req.
   initial begin
      bus_if.imem_ack   = 1'b0;
      bus_if.imem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus_if.imem_ack = 1'b0;
         if (!rst_n || !bus_if.imem_req) begin
            memCnt = 0;
         end else if (memCnt + 1 >= memLat) begin
            bus_if.imem_ack   = 1'b1;
            bus_if.imem_rdata = memWord(bus_if.imem_addr);
            memCnt            = 0;
         end else begin
            memCnt++;
         end
      end
   end

   // Scoreboard monitor: every accepted word must be the next expected one.
   initial begin
      logic [15:0] p, d;
      forever begin
         @(negedge clk);
         if (rst_n && bus_if.instr_valid && bus_if.instr_ready && !redirect) begin
            if (expPc.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_instr: got pc 0x%0h, want none (cycle %0d)", bus_if.instr_pc, cyc);
            end else begin
               p = expPc.pop_front();
               d = expData.pop_front();
               checkOutput("instr_pc", 32'(bus_if.instr_pc), 32'(p));
               checkOutput("instr", 32'(bus_if.instr), 32'(d));
            end
         end
      end
   end

   initial begin
      rst_n              = 1'b0;
      halt               = 1'b0;
      redirect           = 1'b0;
      redirect_pc        = '0;
      bus_if.instr_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      checkOutput("reset_imem_req", 32'(bus_if.imem_req), 32'd0);
      checkOutput("reset_imem_addr", 32'(bus_if.imem_addr), 32'h0000);
      checkOutput("reset_pc", 32'(pc), 32'h0000);
      checkOutput("reset_occupancy", 32'(occupancy), 32'd0);
      checkOutput("reset_instr_valid", 32'(bus_if.instr_valid), 32'd0);
      checkOutput("reset_instr", 32'(bus_if.instr), 32'h0000);
      checkOutput("reset_instr_pc", 32'(bus_if.instr_pc), 32'h0000);

      // Streaming with a 1-cycle memory and an always-ready decode.
      @(posedge clk);
      #1;
      cyc = 0;
      rst_n = 1'b1;
      bus_if.instr_ready = 1'b1;
      expectPc(16'h0000); expectPc(16'h0002); expectPc(16'h0004); expectPc(16'h0006);
      expectPc(16'h0008); expectPc(16'h000A); expectPc(16'h000C);
      for (int k = 1; k <= 6; k++) begin
         waitCycle(k);
         @(negedge clk);
         checkOutput("stream_imem_req", 32'(bus_if.imem_req), 32'd1);
         if (k == 1) begin
            checkOutput("first_imem_addr", 32'(bus_if.imem_addr), 32'h0000);
            checkOutput("first_pc", 32'(pc), 32'h0002);
         end
      end
      applyStimulus(7, 1'b1, 1'b1, 1'b0, 16'h0000);
      waitCycle(8);
      @(negedge clk);
      checkOutput("halt_stop_req", 32'(bus_if.imem_req), 32'd0);
      checkOutput("halt_stop_pc", 32'(pc), 32'h000E);
      waitCycle(10);
      @(negedge clk);
      checkOutput("stream_drained", 32'(occupancy), 32'd0);

      // Backpressure: queue fills to DEPTH with no further requests.
      applyStimulus(11, 1'b0, 1'b0, 1'b0, 16'h0000);
      expectPc(16'h000E); expectPc(16'h0010); expectPc(16'h0012); expectPc(16'h0014);
      expectPc(16'h0016); expectPc(16'h0018); expectPc(16'h001A);
      waitCycle(18);
      @(negedge clk);
      checkOutput("bp_occupancy", 32'(occupancy), 32'd4);
      checkOutput("bp_imem_req", 32'(bus_if.imem_req), 32'd0);
      checkOutput("bp_pc", 32'(pc), 32'h0016);
      checkOutput("bp_instr_valid", 32'(bus_if.instr_valid), 32'd1);
      applyStimulus(19, 1'b0, 1'b1, 1'b0, 16'h0000);
      applyStimulus(22, 1'b1, 1'b1, 1'b0, 16'h0000);
      waitCycle(30);
      @(negedge clk);
      checkOutput("bp_drained", 32'(occupancy), 32'd0);
      checkOutput("bp_final_pc", 32'(pc), 32'h001C);

      // Halt raised while a 3-cycle request is in flight.
      memLat = 3;
      applyStimulus(31, 1'b0, 1'b1, 1'b0, 16'h0000);
      expectPc(16'h001C); expectPc(16'h001E); expectPc(16'h0020);
      applyStimulus(33, 1'b1, 1'b1, 1'b0, 16'h0000);
      waitCycle(35);
      @(negedge clk);
      checkOutput("halt_inflight_req", 32'(bus_if.imem_req), 32'd0);
      checkOutput("halt_inflight_pc", 32'(pc), 32'h001E);
      waitCycle(38);
      @(negedge clk);
      checkOutput("halt_hold_req", 32'(bus_if.imem_req), 32'd0);
      checkOutput("halt_hold_pc", 32'(pc), 32'h001E);
      applyStimulus(39, 1'b0, 1'b1, 1'b0, 16'h0000);
      waitCycle(40);
      @(negedge clk);
      checkOutput("halt_resume_req", 32'(bus_if.imem_req), 32'd1);
      checkOutput("halt_resume_addr", 32'(bus_if.imem_addr), 32'h001E);

      // Redirect while the request for 0x0022 is outstanding: its data is dropped.
      applyStimulus(47, 1'b0, 1'b1, 1'b1, 16'h0100);
      applyStimulus(48, 1'b0, 1'b1, 1'b0, 16'h0000);
      @(negedge clk);
      checkOutput("drop_pc", 32'(pc), 32'h0100);
      checkOutput("drop_hold_addr", 32'(bus_if.imem_addr), 32'h0022);
      checkOutput("drop_hold_req", 32'(bus_if.imem_req), 32'd1);
      memLat = 1;
      applyStimulus(49, 1'b0, 1'b0, 1'b0, 16'h0000);
      expectPc(16'h0100);
      @(negedge clk);
      checkOutput("drop_idle_req", 32'(bus_if.imem_req), 32'd0);
      waitCycle(50);
      @(negedge clk);
      checkOutput("redirect_addr", 32'(bus_if.imem_addr), 32'h0100);
      checkOutput("redirect_req", 32'(bus_if.imem_req), 32'd1);

      // Redirect coincident with an ack and a pop.
      applyStimulus(53, 1'b0, 1'b1, 1'b0, 16'h0000);
      applyStimulus(54, 1'b0, 1'b1, 1'b1, 16'hFFFC);
      @(negedge clk);
      checkOutput("pre_flush_occupancy", 32'(occupancy), 32'd3);
      checkOutput("pre_flush_addr", 32'(bus_if.imem_addr), 32'h0108);
      applyStimulus(55, 1'b0, 1'b1, 1'b0, 16'h0000);
      expectPc(16'hFFFC); expectPc(16'hFFFE); expectPc(16'h0000); expectPc(16'h0002);
      @(negedge clk);
      checkOutput("flush_occupancy", 32'(occupancy), 32'd0);
      checkOutput("flush_instr_valid", 32'(bus_if.instr_valid), 32'd0);
      checkOutput("flush_imem_req", 32'(bus_if.imem_req), 32'd0);
      checkOutput("flush_pc", 32'(pc), 32'hFFFC);

      // Address wrap-around and ack-to-valid latency.
      waitCycle(56);
      @(negedge clk);
      checkOutput("wrap_addr0", 32'(bus_if.imem_addr), 32'hFFFC);
      checkOutput("ack_cycle_valid", 32'(bus_if.instr_valid), 32'(BYPASS_VALID));
      waitCycle(57);
      @(negedge clk);
      checkOutput("wrap_addr1", 32'(bus_if.imem_addr), 32'hFFFE);
      checkOutput("after_ack_valid", 32'(bus_if.instr_valid), 32'd1);
      waitCycle(58);
      @(negedge clk);
      checkOutput("wrap_addr2", 32'(bus_if.imem_addr), 32'h0000);
      applyStimulus(59, 1'b1, 1'b1, 1'b0, 16'h0000);
      waitCycle(63);
      @(negedge clk);
      checkOutput("wrap_final_pc", 32'(pc), 32'h0004);
      checkOutput("wrap_drained", 32'(occupancy), 32'd0);
      checkOutput("wrap_idle_req", 32'(bus_if.imem_req), 32'd0);

      waitCycle(66);
      @(negedge clk);
      checkOutput("scoreboard_leftover", 32'(expPc.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
